// File: rtl/cp0_unit.sv
// cp0_unit: MIPS coprocessor 0 holding SR, Cause, EPC and PRId and raising the flush request Req.
`timescale 1ns/1ps
module cp0_unit #(
   parameter logic [31:0] PRID     = 32'h2023_0007,
   parameter logic [4:0]  INT_CODE = 5'd0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   input  logic [4:0]  CP0Add,
   input  logic [31:0] CP0In,
   output logic [31:0] CP0Out,
   input  logic [31:0] VPC,
   input  logic        BDIn,
   input  logic        Exc_in,
   input  logic [4:0]  ExcCode_in,
   input  logic [5:0]  HWInt,
   input  logic        EXLClr,
   output logic [31:0] EPCOut,
   output logic        Req
);
   logic [5:0]  im, ip;
   logic        exl, ie, bd;
   logic [4:0]  exc_code;
   logic [31:0] epc, sr, cause, vpc_al;
   logic        int_req, exc_req;
   assign sr      = {16'b0, im, 8'b0, exl, ie};
   assign cause   = {bd, 15'b0, ip, 3'b0, exc_code, 2'b0};
   assign int_req = |(HWInt & im) & ie & ~exl;
   assign exc_req = Exc_in & ~exl;
   assign Req     = int_req | exc_req;
   assign vpc_al  = {VPC[31:2], 2'b0};
   assign EPCOut  = epc;
   always_comb
      CP0Out = CP0Add == 5'd12 ? sr :
               CP0Add == 5'd13 ? cause :
               CP0Add == 5'd14 ? epc :
               CP0Add == 5'd15 ? PRID : 32'b0;
   // Req wins over eret and mtc0; within the non-Req path eret overrides an SR write to EXL.
   always_ff @(posedge clk) begin
      if (!reset) begin
         im       <= '0;
         exl      <= 1'b0;
         ie       <= 1'b0;
         bd       <= 1'b0;
         ip       <= '0;
         exc_code <= '0;
         epc      <= '0;
      end else begin
         ip <= HWInt;
         if (Req) begin
            exl      <= 1'b1;
            bd       <= BDIn;
            exc_code <= int_req ? INT_CODE : ExcCode_in;
            epc      <= BDIn ? vpc_al - 32'd4 : vpc_al;
         end else begin
            if (en && CP0Add == 5'd12) begin
               im  <= CP0In[15:10];
               exl <= CP0In[1];
               ie  <= CP0In[0];
            end
            if (en && CP0Add == 5'd14) epc <= {CP0In[31:2], 2'b0};
            if (EXLClr) exl <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_cp0_unit.sv
// tb_cp0_unit: directed self-checking bench for cp0_unit.
`timescale 1ns/1ps
module tb_cp0_unit;
   logic        clk = 1'b0, reset, en, BDIn, Exc_in, EXLClr, Req;
   logic [4:0]  CP0Add, ExcCode_in;
   logic [31:0] CP0In, CP0Out, VPC, EPCOut;
   logic [5:0]  HWInt;
   int total = 0, bad = 0;

   cp0_unit dut (
      .clk(clk), .reset(reset), .en(en), .CP0Add(CP0Add), .CP0In(CP0In), .CP0Out(CP0Out),
      .VPC(VPC), .BDIn(BDIn), .Exc_in(Exc_in), .ExcCode_in(ExcCode_in), .HWInt(HWInt),
      .EXLClr(EXLClr), .EPCOut(EPCOut), .Req(Req)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic rd(input logic [4:0] a, input string tag, input logic [31:0] exp);
      CP0Add = a;
      #1;
      chk(tag, CP0Out, exp);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 0; en = 0; CP0Add = 0; CP0In = 0; VPC = 0; BDIn = 0;
      Exc_in = 0; ExcCode_in = 0; HWInt = 0; EXLClr = 0;
      tick; tick;
      reset = 1;
      #1;
      // 1: reset state
      rd(12, "rst_sr", 32'h0);
      rd(13, "rst_cause", 32'h0);
      rd(14, "rst_epc", 32'h0);
      rd(15, "prid", 32'h2023_0007);
      rd(3, "unmapped", 32'h0);
      chk("rst_req", {31'b0, Req}, 32'h0);
      chk("rst_epcout", EPCOut, 32'h0);
      // 2: plain exception
      Exc_in = 1; ExcCode_in = 4; VPC = 32'h3008; BDIn = 0;
      #1;
      chk("exc_req", {31'b0, Req}, 32'h1);
      tick;
      chk("exc_masked_req", {31'b0, Req}, 32'h0);
      chk("exc_epc", EPCOut, 32'h3008);
      rd(13, "exc_cause", 32'h10);
      rd(12, "exc_sr", 32'h2);
      Exc_in = 0;
      // 3: interrupts
      EXLClr = 1;
      tick;
      EXLClr = 0;
      rd(12, "eret_sr", 32'h0);
      en = 1; CP0Add = 12; CP0In = 32'h401;
      tick;
      en = 0;
      rd(12, "mtc0_sr", 32'h401);
      HWInt = 6'b000001;
      #1;
      chk("int_req", {31'b0, Req}, 32'h1);
      tick;
      rd(13, "int_cause", 32'h400);
      rd(12, "int_sr", 32'h403);
      EXLClr = 1; HWInt = 6'b000010;
      tick;
      EXLClr = 0;
      chk("int_masked_req", {31'b0, Req}, 32'h0);
      rd(13, "int_masked_ip", 32'h800);
      // 4: interrupt beats exception, delay slot
      HWInt = 6'b000001; Exc_in = 1; ExcCode_in = 5; BDIn = 1; VPC = 32'h3010;
      #1;
      chk("both_req", {31'b0, Req}, 32'h1);
      tick;
      Exc_in = 0; HWInt = 0; BDIn = 0;
      rd(13, "both_cause", 32'h8000_0400);
      chk("both_epc", EPCOut, 32'h300C);
      // 5: eret, EPC write, ignored writes
      EXLClr = 1;
      tick;
      EXLClr = 0;
      rd(12, "eret2_sr", 32'h401);
      en = 1; CP0Add = 14; CP0In = 32'h3007;
      #1;
      chk("epc_old_read", CP0Out, 32'h300C);
      chk("epc_no_bypass", EPCOut, 32'h300C);
      tick;
      chk("epc_write", EPCOut, 32'h3004);
      CP0Add = 13; CP0In = 32'hFFFF_FFFF;
      tick;
      CP0Add = 15;
      tick;
      en = 0;
      rd(13, "cause_ro", 32'h8000_0000);
      rd(15, "prid_ro", 32'h2023_0007);
      en = 1; CP0Add = 12; CP0In = 32'h3;
      tick;
      rd(12, "sr_exl_write", 32'h3);
      en = 1; CP0Add = 12; CP0In = 32'hFFFF_FFFF; EXLClr = 1;
      tick;
      en = 0; EXLClr = 0;
      rd(12, "sr_with_eret", 32'hFC01);
      chk("sr_with_eret_req", {31'b0, Req}, 32'h0);
      // 6: Req drops mtc0, wrap-around EPC, reset mid-handler
      Exc_in = 1; ExcCode_in = 6; VPC = 32'h0; BDIn = 1; en = 1; CP0Add = 12; CP0In = 32'h0;
      #1;
      chk("drop_req", {31'b0, Req}, 32'h1);
      tick;
      Exc_in = 0; en = 0; BDIn = 0;
      rd(12, "drop_sr", 32'hFC03);
      chk("wrap_epc", EPCOut, 32'hFFFF_FFFC);
      rd(13, "drop_cause", 32'h8000_0018);
      reset = 0;
      tick;
      reset = 1;
      rd(12, "rst2_sr", 32'h0);
      rd(13, "rst2_cause", 32'h0);
      chk("rst2_epc", EPCOut, 32'h0);
      Exc_in = 1;
      #1;
      chk("rst2_req", {31'b0, Req}, 32'h1);
      Exc_in = 0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
